// File: rtl/uart_reg_bridge_if.sv
// Byte-stream and register-bus signals between uart_reg_bridge (bus master)
// and its environment (UART rx/tx plus register map).
interface uart_reg_bridge_if;
   logic [7:0]  i_rx_data;
   logic        i_rx_valid;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        i_tx_ready;
   logic [15:0] o_addr;
   logic [15:0] o_wdata;
   logic        o_wen;
   logic [15:0] i_q;
   logic        o_busy;
   logic        o_err_timeout;
   logic        o_err_drop;

   modport master (
      input  i_rx_data, i_rx_valid, i_tx_ready, i_q,
      output o_tx_data, o_tx_valid, o_addr, o_wdata, o_wen,
             o_busy, o_err_timeout, o_err_drop
   );

   modport slave (
      output i_rx_data, i_rx_valid, i_tx_ready, i_q,
      input  o_tx_data, o_tx_valid, o_addr, o_wdata, o_wen,
             o_busy, o_err_timeout, o_err_drop
   );
endinterface

// File: rtl/uart_reg_bridge.sv
// Host command parser: decodes 'W'/'R' byte frames into single 16-bit register
// bus writes/reads and returns an ACK byte or the two read-data bytes.
module uart_reg_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 270000,
   parameter int unsigned READ_WAIT      = 2,
   parameter logic [7:0]  CMD_WR         = 8'h57,
   parameter logic [7:0]  CMD_RD         = 8'h52,
   parameter logic [7:0]  ACK_BYTE       = 8'h4B
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   uart_reg_bridge_if.master bus
);

   localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]      RW_LAST = 4'(READ_WAIT - 1);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      ADDR_HI = 4'd1,
      ADDR_LO = 4'd2,
      DATA_HI = 4'd3,
      DATA_LO = 4'd4,
      WRITE   = 4'd5,
      RD_WAIT = 4'd6,
      TX_ACK  = 4'd7,
      TX_HI   = 4'd8,
      TX_LO   = 4'd9
   } state_t;

   state_t          state_r;
   logic            is_wr_r;
   logic [7:0]      addr_hi_r;
   logic [7:0]      wdata_hi_r;
   logic [15:0]     rd_buf_r;
   logic [3:0]      wait_cnt_r;
   logic [TO_W-1:0] to_cnt_r;
   logic [15:0]     addr_r;
   logic [15:0]     wdata_r;
   logic            wen_r;
   logic [7:0]      tx_data_r;
   logic            tx_valid_r;
   logic            busy_r;
   logic            err_timeout_r;
   logic            err_drop_r;

   logic            frame_state_s;
   logic            drop_state_s;
   logic            tx_xfer_s;

   assign tx_xfer_s = tx_valid_r & bus.i_tx_ready;

   // Classify the current state: collecting frame bytes, or unable to take bytes.
   always_comb begin
      frame_state_s = 1'b0;
      drop_state_s  = 1'b0;
      case (state_r)
         ADDR_HI, ADDR_LO, DATA_HI, DATA_LO: frame_state_s = 1'b1;
         WRITE, RD_WAIT, TX_ACK, TX_HI, TX_LO: drop_state_s = 1'b1;
         default: begin
            frame_state_s = 1'b0;
            drop_state_s  = 1'b0;
         end
      endcase
   end

   // Frame FSM with all bus, tx and status outputs registered.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r       <= IDLE;
         is_wr_r       <= 1'b0;
         addr_hi_r     <= 8'h00;
         wdata_hi_r    <= 8'h00;
         rd_buf_r      <= 16'h0000;
         wait_cnt_r    <= 4'd0;
         to_cnt_r      <= {TO_W{1'b0}};
         addr_r        <= 16'h0000;
         wdata_r       <= 16'h0000;
         wen_r         <= 1'b0;
         tx_data_r     <= 8'h00;
         tx_valid_r    <= 1'b0;
         busy_r        <= 1'b0;
         err_timeout_r <= 1'b0;
         err_drop_r    <= 1'b0;
      end else begin
         wen_r         <= 1'b0;
         err_timeout_r <= 1'b0;
         if (frame_state_s && !bus.i_rx_valid) begin
            if (to_cnt_r == TO_LAST) begin
               state_r       <= IDLE;
               busy_r        <= 1'b0;
               err_timeout_r <= 1'b1;
               to_cnt_r      <= {TO_W{1'b0}};
            end else begin
               to_cnt_r <= to_cnt_r + 1'b1;
            end
         end else begin
            // Frame-collecting states only reach here with a byte present.
            case (state_r)
               IDLE: begin
                  if (bus.i_rx_valid &&
                      (bus.i_rx_data == CMD_WR || bus.i_rx_data == CMD_RD)) begin
                     is_wr_r  <= (bus.i_rx_data == CMD_WR);
                     to_cnt_r <= {TO_W{1'b0}};
                     busy_r   <= 1'b1;
                     state_r  <= ADDR_HI;
                  end
               end
               ADDR_HI: begin
                  addr_hi_r <= bus.i_rx_data;
                  to_cnt_r  <= {TO_W{1'b0}};
                  state_r   <= ADDR_LO;
               end
               ADDR_LO: begin
                  addr_r     <= {addr_hi_r, bus.i_rx_data};
                  to_cnt_r   <= {TO_W{1'b0}};
                  wait_cnt_r <= 4'd0;
                  state_r    <= is_wr_r ? DATA_HI : RD_WAIT;
               end
               DATA_HI: begin
                  wdata_hi_r <= bus.i_rx_data;
                  to_cnt_r   <= {TO_W{1'b0}};
                  state_r    <= DATA_LO;
               end
               DATA_LO: begin
                  wdata_r  <= {wdata_hi_r, bus.i_rx_data};
                  to_cnt_r <= {TO_W{1'b0}};
                  wen_r    <= 1'b1;
                  state_r  <= WRITE;
               end
               WRITE: begin
                  tx_data_r  <= ACK_BYTE;
                  tx_valid_r <= 1'b1;
                  state_r    <= TX_ACK;
               end
               RD_WAIT: begin
                  if (wait_cnt_r == RW_LAST) begin
                     rd_buf_r   <= bus.i_q;
                     tx_data_r  <= bus.i_q[15:8];
                     tx_valid_r <= 1'b1;
                     wait_cnt_r <= 4'd0;
                     state_r    <= TX_HI;
                  end else begin
                     wait_cnt_r <= wait_cnt_r + 4'd1;
                  end
               end
               TX_ACK, TX_LO: begin
                  if (tx_xfer_s) begin
                     tx_valid_r <= 1'b0;
                     busy_r     <= 1'b0;
                     state_r    <= IDLE;
                  end
               end
               TX_HI: begin
                  if (tx_xfer_s) begin
                     tx_data_r <= rd_buf_r[7:0];
                     state_r   <= TX_LO;
                  end
               end
               default: begin
                  tx_valid_r <= 1'b0;
                  busy_r     <= 1'b0;
                  state_r    <= IDLE;
               end
            endcase
         end
         if (bus.i_rx_valid && drop_state_s) begin
            err_drop_r <= 1'b1;
         end
      end
   end

   assign bus.o_addr        = addr_r;
   assign bus.o_wdata       = wdata_r;
   assign bus.o_wen         = wen_r;
   assign bus.o_tx_data     = tx_data_r;
   assign bus.o_tx_valid    = tx_valid_r;
   assign bus.o_busy        = busy_r;
   assign bus.o_err_timeout = err_timeout_r;
   assign bus.o_err_drop    = err_drop_r;

endmodule

// File: doc/uart_reg_bridge.md
Name: uart_reg_bridge

Overview:
Command parser between the UART receiver/transmitter byte streams and the register map bus (addr/wdata/wen/q). It decodes host frames into single 16-bit register writes or reads, drives the register bus, and returns an ACK byte or read data bytes to the UART transmitter. One frame is in flight at a time; the bridge is the only master on the register bus.

Parameters:
TIMEOUT_CYCLES, 270000, inter-byte timeout inside a frame, in i_clk cycles (10 ms at 27 MHz); counter width = $clog2(TIMEOUT_CYCLES+1)
READ_WAIT, 2, cycles between o_addr update and i_q capture (covers the registered read path); legal range 1..15
CMD_WR, 8'h57, write command byte ('W')
CMD_RD, 8'h52, read command byte ('R')
ACK_BYTE, 8'h4B, write acknowledge byte ('K')

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_rx_data  in  8  received byte
i_rx_valid  in  1  single-cycle strobe, i_rx_data valid; no backpressure
o_tx_data  out  8  byte to transmit
o_tx_valid  out  1  o_tx_data valid
i_tx_ready  in  1  transmitter accepts byte when high with o_tx_valid
o_addr  out  16  register bus address
o_wdata  out  16  register bus write data
o_wen  out  1  register bus write enable, one-cycle pulse
i_q  in  16  register bus read data
o_busy  out  1  high whenever FSM not in IDLE
o_err_timeout  out  1  one-cycle pulse on frame timeout abort
o_err_drop  out  1  sticky: a byte arrived while sending a response and was dropped; cleared only by reset

Behaviour:
- Reset (asynchronous, active-low) -> state IDLE; o_addr=0, o_wdata=0, o_wen=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_err_timeout=0, o_err_drop=0, timeout counter=0. Reset mid-frame or mid-transmit abandons the frame with no bus write and no further tx.
- All outputs registered.
- Frames: write = CMD_WR, A[15:8], A[7:0], D[15:8], D[7:0]; read = CMD_RD, A[15:8], A[7:0]. Big-endian.
- States: IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, WRITE, RD_WAIT, TX_ACK, TX_HI, TX_LO.
- IDLE: rx byte == CMD_WR or CMD_RD -> ADDR_HI, latch command type; any other byte ignored silently (stay IDLE, no error).
- ADDR_HI: byte -> o_addr[15:8] staging reg; ADDR_LO: byte -> o_addr updated with full 16-bit address at this edge; then write -> DATA_HI, read -> RD_WAIT.
- DATA_HI/DATA_LO: collect o_wdata; o_wdata updated at DATA_LO byte edge; -> WRITE.
- WRITE: o_wen=1 for exactly one cycle, with o_addr/o_wdata stable; -> TX_ACK.
- RD_WAIT: count READ_WAIT cycles after the o_addr update, o_wen held 0; capture i_q into 16-bit read buffer on final count; -> TX_HI.
- TX_*: o_tx_valid=1 with o_tx_data stable until cycle where i_tx_ready=1 (transfer); TX_ACK sends ACK_BYTE -> IDLE; TX_HI sends q[15:8] -> TX_LO; TX_LO sends q[7:0] -> IDLE. o_tx_valid drops the cycle after last transfer unless reissued. Back-to-back transfers allowed.
- Timeout: in ADDR_HI, ADDR_LO, DATA_HI, DATA_LO counter increments each cycle without i_rx_valid, clears on each accepted byte and on entry from IDLE; on reaching TIMEOUT_CYCLES -> IDLE, pulse o_err_timeout, no bus write, no tx. A byte arriving in the same cycle as expiry is accepted (byte wins).
- Bytes arriving in WRITE, RD_WAIT, or TX_* states are dropped and set o_err_drop.
- o_addr and o_wdata hold last values between frames; o_wen is 0 outside WRITE.
- o_wen never asserted for read frames; at most one write per frame.

Test Plan:
- Write: rx 57 00 04 12 34 -> one o_wen pulse with o_addr=0x0004, o_wdata=0x1234; then tx byte 4B; o_busy returns 0.
- Read: preload reg 0x0004=0x1234 via write; rx 52 00 04 -> exactly READ_WAIT cycles after o_addr=0x0004, capture; tx 12 then 34; no o_wen.
- Backpressure: read frame with i_tx_ready held low 20 cycles -> o_tx_valid=1, o_tx_data=12 stable throughout; bytes sent in order once ready rises.
- Timeout (TIMEOUT_CYCLES=100 in bench): rx 57 00 then idle 100 cycles -> o_err_timeout pulse, state IDLE, no o_wen; subsequent full write frame works.
- Garbage/drop: rx AA 52 00 10 -> AA ignored, read of 0x0010 proceeds; extra byte 55 sent during TX_HI -> dropped, o_err_drop=1 and stays 1 until reset.
- Reset mid-frame: assert i_rst_n low after rx 57 00 04 12 -> all outputs at reset values immediately; after release, no o_wen and no tx.
